// File: rtl/online_add_sequencer.sv
// Drives one radix-4 MSD-first addition through online_adder_r4 and collects the N+1 result digits.
// Define ONLINE_SEQ_CHECK_EN to build the numeric self-check behind the pass output.
module online_add_sequencer #(
    parameter int N     = 6,
    parameter int C     = 3,
    parameter int DELAY = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [N*C-1:0]     x_in,
    input  logic [N*C-1:0]     y_in,
    output logic               busy,
    output logic               done,
    output logic [(N+1)*C-1:0] result,
    output logic               pass,
    output logic               adder_reset,
    output logic               adder_en,
    output logic [C-1:0]       adder_xi,
    output logic [C-1:0]       adder_yi,
    input  logic [C-1:0]       adder_zi
);
    localparam int KW = $clog2(N + DELAY + 1);
    localparam logic [KW-1:0] K_LAST = KW'(N + DELAY - 1);

    typedef enum logic [1:0] {S_IDLE, S_CLR, S_FEED, S_DONE} state_t;

    state_t           r_state, w_state_next;
    logic [N*C-1:0]   r_xs, r_ys, w_xs_next, w_ys_next;
    logic [KW-1:0]    r_k, w_k_next, w_k_inc;
    logic [C-1:0]     r_res [0:N];
    logic [C-1:0]     w_res_next [0:N];
    logic             r_busy, r_done, r_pass, r_adder_reset, r_adder_en;
    logic             w_busy_next, w_done_next, w_pass_next, w_adder_reset_next, w_adder_en_next;
    logic [C-1:0]     r_xi, r_yi, w_xi_next, w_yi_next;
    logic [C-1:0]     w_xd [0:N-1];
    logic [C-1:0]     w_yd [0:N-1];
    logic             w_check_ok;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_unpack
            assign w_xd[gi] = r_xs[(N-gi)*C-1 -: C];
            assign w_yd[gi] = r_ys[(N-gi)*C-1 -: C];
        end
        for (gi = 0; gi <= N; gi++) begin : g_pack
            assign result[(N+1-gi)*C-1 -: C] = r_res[gi];
        end
    endgenerate

`ifdef ONLINE_SEQ_CHECK_EN
    localparam int W = 2*N + 3;
    logic [W-1:0] w_vx, w_vy, w_vr;

    // Horner evaluation on sign-extended digits; modulo-2^W equality is exact at this width.
    always_comb begin
        w_vx = '0;
        w_vy = '0;
        w_vr = '0;
        for (int i = 0; i < N; i++) begin
            w_vx = (w_vx << 2) + {{(W-C){w_xd[i][C-1]}}, w_xd[i]};
            w_vy = (w_vy << 2) + {{(W-C){w_yd[i][C-1]}}, w_yd[i]};
        end
        for (int j = 0; j <= N; j++) begin
            w_vr = (w_vr << 2) + {{(W-C){w_res_next[j][C-1]}}, w_res_next[j]};
        end
        w_check_ok = (w_vr == w_vx + w_vy);
    end
`else
    assign w_check_ok = 1'b0;
`endif

    assign w_k_inc = r_k + 1'b1;

    always_comb begin
        w_state_next       = r_state;
        w_xs_next          = r_xs;
        w_ys_next          = r_ys;
        w_k_next           = r_k;
        w_res_next         = r_res;
        w_busy_next        = r_busy;
        w_done_next        = 1'b0;
        w_pass_next        = r_pass;
        w_adder_reset_next = 1'b0;
        w_adder_en_next    = 1'b0;
        w_xi_next          = '0;
        w_yi_next          = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_xs_next          = x_in;
                    w_ys_next          = y_in;
                    for (int j = 0; j <= N; j++) w_res_next[j] = '0;
                    w_pass_next        = 1'b0;
                    w_busy_next        = 1'b1;
                    w_adder_reset_next = 1'b1;
                    w_state_next       = S_CLR;
                end
            end
            S_CLR: begin
                w_k_next        = '0;
                w_adder_en_next = 1'b1;
                w_xi_next       = w_xd[0];
                w_yi_next       = w_yd[0];
                w_state_next    = S_FEED;
            end
            S_FEED: begin
                // Output digit j appears DELAY-1 feed cycles after input digit j.
                for (int j = 0; j <= N; j++) begin
                    if (r_k == KW'(j + DELAY - 1)) w_res_next[j] = adder_zi;
                end
                if (r_k == K_LAST) begin
                    w_done_next  = 1'b1;
                    w_pass_next  = w_check_ok;
                    w_state_next = S_DONE;
                end else begin
                    w_k_next        = w_k_inc;
                    w_adder_en_next = 1'b1;
                    for (int i = 0; i < N; i++) begin
                        if (w_k_inc == KW'(i)) begin
                            w_xi_next = w_xd[i];
                            w_yi_next = w_yd[i];
                        end
                    end
                end
            end
            S_DONE: begin
                w_busy_next  = 1'b0;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_xs          <= '0;
            r_ys          <= '0;
            r_k           <= '0;
            for (int j = 0; j <= N; j++) r_res[j] <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_adder_reset <= 1'b0;
            r_adder_en    <= 1'b0;
            r_xi          <= '0;
            r_yi          <= '0;
        end else begin
            r_state       <= w_state_next;
            r_xs          <= w_xs_next;
            r_ys          <= w_ys_next;
            r_k           <= w_k_next;
            r_res         <= w_res_next;
            r_busy        <= w_busy_next;
            r_done        <= w_done_next;
            r_pass        <= w_pass_next;
            r_adder_reset <= w_adder_reset_next;
            r_adder_en    <= w_adder_en_next;
            r_xi          <= w_xi_next;
            r_yi          <= w_yi_next;
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign adder_reset = r_adder_reset;
    assign adder_en    = r_adder_en;
    assign adder_xi    = r_xi;
    assign adder_yi    = r_yi;
endmodule

// File: tb/tb_online_add_sequencer.sv
// Bench for online_add_sequencer: behavioural stand-in for the adder, per-cycle control checks,
// and a scoreboard of expected result/pass popped on each done.
module tb_online_add_sequencer;
    localparam int N = 6;
    localparam int C = 3;
    localparam int DELAY = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [N*C-1:0]     x_in, y_in;
    logic               busy, done, pass;
    logic [(N+1)*C-1:0] result;
    logic               adder_reset, adder_en;
    logic [C-1:0]       adder_xi, adder_yi, adder_zi;

    online_add_sequencer #(.N(N), .C(C), .DELAY(DELAY)) dut (
        .clk(clk), .reset(reset), .start(start), .x_in(x_in), .y_in(y_in),
        .busy(busy), .done(done), .result(result), .pass(pass),
        .adder_reset(adder_reset), .adder_en(adder_en),
        .adder_xi(adder_xi), .adder_yi(adder_yi), .adder_zi(adder_zi)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [(N+1)*C-1:0] res;
        logic               pass;
    } exp_t;
    exp_t sb_q[$];

    int n_vec = 0;
    int n_err = 0;
    int n_done = 0;
    int n_done_exp = 0;

    int xa[N];
    int ya[N];
    int model_dig[N+1];
    int force_k = -1;
    int adder_cnt = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Adder stand-in: emits the bench's own digits of the sum, DELAY-1 feed cycles late.
    always @(posedge clk) begin
        if (adder_reset) adder_cnt <= 0;
        else if (adder_en) adder_cnt <= adder_cnt + 1;
    end

    always_comb begin
        adder_zi = '0;
        if (adder_en && adder_cnt >= DELAY-1 && adder_cnt <= N+DELAY-1) begin
            if (adder_cnt == force_k) adder_zi = 3'd1;
            else adder_zi = C'(model_dig[adder_cnt-DELAY+1]);
        end
    end

    always @(negedge clk) begin
        if (done) begin
            n_done++;
            if (sb_q.size() == 0) begin
                check_val("sb_underflow", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                $display("run %0d: result=%h pass=%b (expected %h/%b)", n_done, result, pass, e.res, e.pass);
                check_val("result", 64'(result), 64'(e.res));
                check_val("pass", 64'(pass), 64'(e.pass));
            end
        end
    end

    task automatic run(input int fk, input bit extra_start, input bit abort);
        logic [N*C-1:0] xp, yp;
        int   dig[N+1];
        int   vx, vy, s, vr, r;
        exp_t e;
        vx = 0; vy = 0;
        for (int k = 0; k < N; k++) begin
            xp[(N-k)*C-1 -: C] = C'(xa[k]);
            yp[(N-k)*C-1 -: C] = C'(ya[k]);
            vx = vx*4 + xa[k];
            vy = vy*4 + ya[k];
        end
        s = vx + vy;
        for (int j = N; j >= 1; j--) begin
            r = ((s % 4) + 4) % 4;
            dig[j] = r;
            s = (s - r) / 4;
        end
        dig[0] = s;
        model_dig = dig;
        if (fk >= 0) dig[fk-DELAY+1] = 1;
        vr = 0;
        for (int j = 0; j <= N; j++) begin
            vr = vr*4 + dig[j];
            e.res[(N+1-j)*C-1 -: C] = C'(dig[j]);
        end
`ifdef ONLINE_SEQ_CHECK_EN
        e.pass = (vr == vx + vy);
`else
        e.pass = 1'b0;
`endif
        sb_q.push_back(e);
        if (!abort) n_done_exp++;

        @(negedge clk);
        force_k = fk;
        x_in = xp;
        y_in = yp;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        x_in = 18'($urandom);
        y_in = 18'($urandom);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (extra_start) start = (c == 4);
            if (abort && c == 5) begin
                #2 reset = 1'b1;
                #1;
                check_val("abort_state", 64'({busy, done, adder_en, adder_reset, result}), 64'd0);
                void'(sb_q.pop_back());
                @(negedge clk);
                reset = 1'b0;
                force_k = -1;
                return;
            end
            if (c == 1) begin
                check_val("clr_cycle", 64'({busy, done, adder_reset, adder_en, adder_xi, adder_yi}), 64'b1010_000000);
            end else if (c <= 9) begin
                logic [C-1:0] ex, ey;
                ex = (c-2 < N) ? C'(xa[c-2]) : '0;
                ey = (c-2 < N) ? C'(ya[c-2]) : '0;
                check_val($sformatf("feed_k%0d", c-2),
                          64'({busy, done, adder_reset, adder_en, adder_xi, adder_yi}),
                          64'({4'b1001, ex, ey}));
            end else if (c == 10) begin
                check_val("done_cycle", 64'({busy, done, adder_reset, adder_en}), 64'b1100);
            end else begin
                check_val($sformatf("idle_c%0d", c), 64'({busy, done, adder_reset, adder_en}), 64'd0);
            end
        end
        force_k = -1;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        x_in  = '0;
        y_in  = '0;
        repeat (3) @(negedge clk);
        check_val("reset_state",
                  64'({busy, done, pass, adder_reset, adder_en, adder_xi, adder_yi, result}), 64'd0);
        reset = 1'b0;

        xa = '{0, 0, 0, 0, 0, 0};  ya = '{0, 0, 0, 0, 0, 0};
        run(-1, 1'b0, 1'b0);
        xa = '{1, 2, -2, 0, 0, 0}; ya = '{1, -1, 3, 0, 0, 0};
        run(-1, 1'b0, 1'b0);
        xa = '{3, 3, 3, 3, 3, 3};  ya = '{3, 3, 3, 3, 3, 3};
        run(-1, 1'b0, 1'b0);
        check_val("carry_digit0", 64'(result[(N+1)*C-1 -: C]), 64'd1);
        xa = '{1, 0, 0, 0, 0, 0};  ya = '{0, 0, 0, 0, 0, 0};
        run(3, 1'b0, 1'b0);
        xa = '{-4, -4, -4, -4, -4, -4}; ya = '{-3, -4, -2, -4, -1, -4};
        run(-1, 1'b0, 1'b0);
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < N; k++) begin
                xa[k] = int'($urandom_range(0, 7)) - 4;
                ya[k] = int'($urandom_range(0, 7)) - 4;
            end
            run(-1, (t == 0), 1'b0);
        end
        xa = '{3, -1, 2, 3, 1, -2}; ya = '{2, 2, -3, 1, 0, 3};
        run(-1, 1'b0, 1'b1);
        run(-1, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check_val("done_count", 64'(n_done), 64'(n_done_exp));
        check_val("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
